// File: rtl/hdr_writer_if.sv
// Header writer bus: packet input stream, header RAM write port and the
// ownership handshake with the header reader.
interface hdr_writer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [5:0]  max_hdr_mgmt;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic [5:0]  hdr_len;
  logic        hdr_valid;
  logic        hdr_done;
  logic        trunc_flag;
  logic        err_sop;

  // Packet source / reader side
  modport master (
    output in_data, in_valid, in_sop, in_eop, max_hdr_mgmt, hdr_done,
    input  in_ready, wr_en, wr_addr, wr_data, hdr_len, hdr_valid,
           trunc_flag, err_sop
  );

  // Header writer side
  modport slave (
    input  in_data, in_valid, in_sop, in_eop, max_hdr_mgmt, hdr_done,
    output in_ready, wr_en, wr_addr, wr_data, hdr_len, hdr_valid,
           trunc_flag, err_sop
  );
endinterface

// File: rtl/hdr_writer.sv
// Header writer: captures the first max_hdr_mgmt+1 words of each packet into
// a header RAM, then hands the buffer to the reader until it pulses hdr_done.
module hdr_writer (
  input logic         clk,
  input logic         rst,
  hdr_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2,
    READY   = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic [5:0]  wr_ptr_q,    wr_ptr_d;
  logic [5:0]  max_q,       max_d;
  logic        wr_en_q,     wr_en_d;
  logic [5:0]  wr_addr_q,   wr_addr_d;
  logic [63:0] wr_data_q,   wr_data_d;
  logic [5:0]  hdr_len_q,   hdr_len_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        trunc_q,     trunc_d;
  logic        err_sop_q,   err_sop_d;

  logic in_ready;
  logic accept;

  // The buffer is blocked only while the reader owns it.
  assign in_ready = (state_q != READY);
  assign accept   = bus.in_valid && in_ready;

  // Next-state and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    max_d       = max_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    hdr_len_d   = hdr_len_q;
    hdr_valid_d = 1'b0;
    trunc_d     = trunc_q;
    err_sop_d   = 1'b0;

    case (state_q)
      READY: begin
        // hdr_done only counts once the reader has been told the header is
        // valid; the first READY cycle still lets the last write commit.
        if (bus.hdr_done && hdr_valid_q) begin
          state_d = IDLE;
        end else begin
          hdr_valid_d = 1'b1;
        end
      end

      default: begin
        if (accept) begin
          if (bus.in_sop) begin
            // Start of packet, legal in IDLE; in CAPTURE/SKIP it flags the
            // lost end of the previous packet and restarts capture.
            err_sop_d = (state_q != IDLE);
            wr_en_d   = 1'b1;
            wr_addr_d = 6'd0;
            wr_data_d = bus.in_data;
            max_d     = bus.max_hdr_mgmt;
            hdr_len_d = 6'd0;
            trunc_d   = 1'b0;
            if (bus.in_eop) begin
              state_d  = READY;
              wr_ptr_d = 6'd0;
            end else if (bus.max_hdr_mgmt == 6'd0) begin
              state_d  = SKIP;
              trunc_d  = 1'b1;
              wr_ptr_d = 6'd0;
            end else begin
              state_d  = CAPTURE;
              wr_ptr_d = 6'd1;
            end
          end else if (state_q == IDLE) begin
            // Word outside any packet: dropped and reported.
            err_sop_d = 1'b1;
          end else if (state_q == CAPTURE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = bus.in_data;
            if (bus.in_eop) begin
              state_d   = READY;
              hdr_len_d = wr_ptr_q;
              wr_ptr_d  = 6'd0;
            end else if (wr_ptr_q == max_q) begin
              // Header limit reached: the pointer stops here, never wraps.
              state_d   = SKIP;
              trunc_d   = 1'b1;
              hdr_len_d = max_q;
              wr_ptr_d  = 6'd0;
            end else begin
              wr_ptr_d = wr_ptr_q + 6'd1;
            end
          end else begin
            // SKIP: payload beyond the header is consumed without writes.
            if (bus.in_eop) begin
              state_d = READY;
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the write-port registers are reset too, so the RAM never sees a
      // stray strobe after reset; the RAM contents themselves are not reset,
      // they are simply not owned by the reader until a new header lands.
      state_q     <= IDLE;
      wr_ptr_q    <= 6'd0;
      max_q       <= 6'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 64'd0;
      hdr_len_q   <= 6'd0;
      hdr_valid_q <= 1'b0;
      trunc_q     <= 1'b0;
      err_sop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      max_q       <= max_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      hdr_len_q   <= hdr_len_d;
      hdr_valid_q <= hdr_valid_d;
      trunc_q     <= trunc_d;
      err_sop_q   <= err_sop_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.hdr_len    = hdr_len_q;
  assign bus.hdr_valid  = hdr_valid_q;
  assign bus.trunc_flag = trunc_q;
  assign bus.err_sop    = err_sop_q;

endmodule
